instr_fetch_queue: RTL
======================

// Module: instr_fetch_queue
// PURPOSE
//   Fetch stage plus instruction queue for the MCU. It generates sequential fetch addresses
//   into the 1-cycle-latency synchronous instruction memory. Returned words are buffered with
//   their PC in a small FIFO. The head entry is presented to decode; DEC_IMM_FIELD (IR[31:7])
//   drives the immediate generator directly. A REDIRECT (taken branch/jump/trap) flushes all state.
// PARAMETERS
//   DEPTH     4          queue entries; power of 2, >= 2
//   RESET_PC  32'h0      first fetch address after reset; bits [1:0] must be 0
// PORTS
//   CLK            in   1              system clock, rising edge
//   RST_N          in   1              asynchronous, active-low reset
//   MEM_RDEN       out  1              fetch request this cycle
//   MEM_ADDR       out  32             fetch address (word aligned)
//   MEM_DOUT       in   32             instruction word, valid the cycle after MEM_RDEN
//   REDIRECT       in   1              flush queue and restart fetch at REDIRECT_PC
//   REDIRECT_PC    in   32             new fetch address; bits [1:0] ignored (forced 0)
//   DEC_VALID      out  1              head entry valid
//   DEC_READY      in   1              decode accepts head entry
//   DEC_IR         out  32             head instruction
//   DEC_PC         out  32             PC of head instruction
//   DEC_IMM_FIELD  out  25             DEC_IR[31:7], feeds immediate generator
//   FQ_COUNT       out  $clog2(DEPTH)+1  entries currently held
// BEHAVIOUR
//   - Reset (async, immediate): fetch_pc=RESET_PC, inflight=0, count=0, rd/wr ptr=0.
//     Outputs: MEM_RDEN=0 while RST_N=0, DEC_VALID=0, FQ_COUNT=0.
//   - Empty queue: DEC_IR=32'h00000013 (NOP), DEC_PC=0, DEC_IMM_FIELD=NOP[31:7].
//   - MEM_RDEN = RST_N & ~REDIRECT & (count + inflight < DEPTH); MEM_ADDR = fetch_pc (comb.).
//   - On MEM_RDEN: fetch_pc <= fetch_pc+4, mod 2^32 (32'hFFFFFFFC wraps to 0).
//     Set inflight<=1 and capture inflight_pc<=fetch_pc. Otherwise inflight<=0.
//   - Response: if inflight & ~REDIRECT, push {MEM_DOUT, inflight_pc} at wr_ptr.
//   - Credit rule guarantees no push when full; overflow is impossible by construction.
//   - Pop: DEC_VALID & DEC_READY advances rd_ptr. DEC_VALID = (count!=0) & ~REDIRECT.
//   - Push+pop same cycle: count unchanged, both pointers advance; FIFO order preserved.
//   - Pointers wrap modulo DEPTH; count distinguishes full from empty.
//   - REDIRECT (highest priority over push/pop):
//     count<=0, ptrs<=0, inflight<=0 (in-flight word discarded), fetch_pc<={REDIRECT_PC[31:2],2'b00}.
//     MEM_RDEN=0 that cycle; the first request at the new PC is issued the next cycle.
//   - Latency: request in cycle N -> entry pushed end of N+1 -> DEC_VALID in N+2.
//     Throughput is 1 instr/cycle with DEC_READY held high.
//   - REDIRECT held several cycles: fetch stays stalled, fetch_pc re-loads each cycle.
//   - Async reset mid-operation discards all entries and any in-flight word.
//     Fetch restarts at RESET_PC on the first edge after RST_N rises.
// TESTING
//   1 RST_N rises, RESET_PC=0, DEC_READY=1, memory returns the addr as data
//     -> MEM_ADDR 0,4,8,... on consecutive cycles; DEC_VALID from cycle 2; DEC_PC 0,4,8 back-to-back.
//   2 DEC_READY=0 from reset -> exactly 4 requests (0x0..0xC), then MEM_RDEN=0 and FQ_COUNT=4.
//     Raise DEC_READY -> DEC_PC 0,4,8,C in order; fetch resumes at 0x10.
//   3 Full queue plus one in flight, pulse REDIRECT with REDIRECT_PC=0x103
//     -> next cycle FQ_COUNT=0, DEC_VALID=0, MEM_ADDR=0x100; no stale word ever reaches decode.
//   4 REDIRECT_PC=0xFFFFFFF8 -> MEM_ADDR sequence FFFFFFF8, FFFFFFFC, 00000000, 00000004.
//   5 Memory word 0xFE010113 at head -> DEC_IMM_FIELD=25'h1FC0202.
//     Push and pop in the same cycle keep FQ_COUNT constant.
//   6 Drop RST_N between clock edges mid-stream -> DEC_VALID, MEM_RDEN and FQ_COUNT go 0 with no clock edge.
//     After release, first MEM_ADDR=RESET_PC.

Source files
------------

// File: rtl/instr_fetch_queue.sv
// Fetch stage and instruction queue: issues sequential word fetches with credit-based
// flow control into a 1-cycle-latency memory and buffers returned words with their PCs.
module instr_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  output logic                      mem_rden_o,
  output logic [31:0]               mem_addr_o,
  input  logic [31:0]               mem_dout_i,
  input  logic                      redirect_i,
  input  logic [31:0]               redirect_pc_i,
  output logic                      dec_valid_o,
  input  logic                      dec_ready_i,
  output logic [31:0]               dec_ir_o,
  output logic [31:0]               dec_pc_o,
  output logic [24:0]               dec_imm_field_o,
  output logic [$clog2(DEPTH):0]    fq_count_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [CW:0] DEPTH_C = DEPTH[CW:0];

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic          inflight_q, inflight_d;
  logic [31:0]   inflight_pc_q, inflight_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]   ir_q [DEPTH];
  logic [31:0]   pc_q [DEPTH];

  logic credit_ok, push, pop, not_empty;

  // A request is allowed only if its word is guaranteed a free slot on return.
  assign credit_ok   = ({1'b0, count_q} + {{CW{1'b0}}, inflight_q}) < DEPTH_C;
  assign mem_rden_o  = rst_n_i & ~redirect_i & credit_ok;
  assign mem_addr_o  = fetch_pc_q;

  assign not_empty   = (count_q != '0);
  assign push        = inflight_q & ~redirect_i;
  assign dec_valid_o = not_empty & ~redirect_i;
  assign pop         = dec_valid_o & dec_ready_i;

  assign dec_ir_o        = not_empty ? ir_q[rd_ptr_q] : NOP;
  assign dec_pc_o        = not_empty ? pc_q[rd_ptr_q] : 32'h0;
  assign dec_imm_field_o = dec_ir_o[31:7];
  assign fq_count_o      = count_q;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = mem_rden_o;
    inflight_pc_d = mem_rden_o ? fetch_pc_q : inflight_pc_q;
    count_d       = count_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    if (redirect_i) begin
      fetch_pc_d = redirect_pc_i & 32'hFFFF_FFFC;
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
    end else begin
      if (mem_rden_o) fetch_pc_d = fetch_pc_q + 32'd4;
      if (push)       wr_ptr_d   = wr_ptr_q + 1'b1;
      if (pop)        rd_ptr_d   = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'h0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  // Queue storage needs no reset: count_q alone decides which slots are meaningful.
  always_ff @(posedge clk_i) begin
    if (push) begin
      ir_q[wr_ptr_q] <= mem_dout_i;
      pc_q[wr_ptr_q] <= inflight_pc_q;
    end
  end
endmodule
